// File: rtl/operand_fetch.sv
// operand_fetch: arbitrates operand reads against writeback on a shared
// register file and forwards late writebacks into the fetched operands.
module operand_fetch #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  rf_a1,
  output logic [4:0]  rf_a2,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic        rf_we3,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_rs1_data,
  output logic [31:0] op_rs2_data
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    OUT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   wait_cnt, wait_n;
  logic [4:0]      rs1_q, rs2_q;
  logic [31:0]     d1_n, d2_n;
  logic            starved;
  logic            read_win;
  logic            wr;

  function automatic logic [31:0] pick(
    input logic [4:0]  rs,
    input logic [31:0] rd,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    if (rs == 5'd0)
      return 32'd0;
    else if (we && wa == rs)
      return wd;
    else
      return rd;
  endfunction

  assign starved  = (wait_cnt == LIMIT);
  assign read_win = !reset && state == IDLE && req_valid &&
                    (!wb_valid || starved);

  assign req_ready = read_win;
  assign wb_ready  = !reset && !read_win;

  // Writes to x0 are accepted but never reach the file.
  assign wr     = wb_valid && wb_ready && wb_rd != 5'd0;
  assign rf_we3 = wr;
  assign rf_a3  = wb_rd;
  assign rf_wd3 = wb_data;
  assign rf_a1  = req_rs1;
  assign rf_a2  = req_rs2;

  assign op_valid = (state == OUT);

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    d1_n    = op_rs1_data;
    d2_n    = op_rs2_data;
    unique case (state)
      IDLE: begin
        if (read_win) begin
          state_n = CAPT;
          wait_n  = '0;
        end else if (req_valid && wb_valid && !starved) begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      CAPT: begin
        d1_n    = pick(rs1_q, rf_rd1, wr, wb_rd, wb_data);
        d2_n    = pick(rs2_q, rf_rd2, wr, wb_rd, wb_data);
        state_n = OUT;
      end
      OUT: begin
        d1_n = pick(rs1_q, op_rs1_data, wr, wb_rd, wb_data);
        d2_n = pick(rs2_q, op_rs2_data, wr, wb_rd, wb_data);
        if (op_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      op_rs1_data <= '0;
      op_rs2_data <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      op_rs1_data <= d1_n;
      op_rs2_data <= d2_n;
      if (read_win) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
      end
    end
  end

endmodule
